fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the pipelined processor. It owns the PC, drives the instruction memory address, and latches each fetched instruction with its PC+2. It presents the 5-bit opcode directly to the decode-stage control block. It honours stall and branch/jump redirect requests from downstream, stops fetching once a HALT has been fetched, and injects NOPs on flush.

---
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC and IF/ID pipeline register.
// Latency: one cycle from imem_addr to instr_out; imem_addr is combinational from PC.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall and flushes IF/ID.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_addr         instruction memory address (equals PC)
//   imem_data         instruction word at imem_addr, same cycle
//   stall             hold PC, IF/ID and halted
//   redirect          flush IF/ID and load redirect_pc
//   redirect_pc       redirect target
//   instr_out         IF/ID instruction word
//   opcode_out        instr_out[15:11] for decode control
//   pc2_out           PC+2 of the instruction in IF/ID
//   valid_out         IF/ID holds a real fetched instruction
//   halted            a HALT was fetched on the current path
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [4:0]  opcode_out,
  output logic [15:0] pc2_out,
  output logic        valid_out,
  output logic        halted
);

  localparam logic [4:0] OP_HALT = 5'b00000;

  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_is_halt;

  // Wraps modulo 2^16 with no carry out.
  assign pc_plus2      = pc + 16'd2;
  assign fetch_is_halt = (imem_data[15:11] == OP_HALT);

  assign imem_addr  = pc;
  assign opcode_out = instr_out[15:11];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr_out <= NOP_INSTR;
      pc2_out   <= 16'h0000;
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      // Current imem_data is on the wrong path; drop it and any pending HALT.
      pc        <= redirect_pc;
      instr_out <= NOP_INSTR;
      pc2_out   <= 16'h0000;
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (stall) begin
      pc        <= pc;
      instr_out <= instr_out;
      pc2_out   <= pc2_out;
      valid_out <= valid_out;
      halted    <= halted;
    end else if (halted) begin
      // PC parks on the HALT address; only bubbles flow downstream.
      pc        <= pc;
      instr_out <= NOP_INSTR;
      pc2_out   <= 16'h0000;
      valid_out <= 1'b0;
      halted    <= 1'b1;
    end else begin
      instr_out <= imem_data;
      pc2_out   <= pc_plus2;
      valid_out <= 1'b1;
      if (fetch_is_halt) begin
        pc     <= pc;
        halted <= 1'b1;
      end else begin
        pc     <= pc_plus2;
        halted <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory.
// Latency: checks sample one time unit after each rising edge.
// Backpressure: stall/redirect driven directly as directed steps.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [4:0]  opcode_out;
  logic [15:0] pc2_out;
  logic        valid_out;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_out  (instr_out),
    .opcode_out (opcode_out),
    .pc2_out    (pc2_out),
    .valid_out  (valid_out),
    .halted     (halted)
  );

  // Background memory contents: ADDI-style word (opcode 00100) tagged with low address bits.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    return 16'h2000 | (a & 16'h07FF);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                           input logic [15:0] pc2, input logic vld, input logic hlt);
    check({tag, ".addr"},   imem_addr, addr);
    check({tag, ".instr"},  instr_out, instr);
    check({tag, ".opcode"}, 16'(opcode_out), 16'(instr[15:11]));
    check({tag, ".pc2"},    pc2_out, pc2);
    check({tag, ".valid"},  16'(valid_out), 16'(vld));
    check({tag, ".halted"}, 16'(halted), 16'(hlt));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = word_at(16'(i));
    mem[16'h0006] = 16'h0000;   // HALT
    mem[16'hFFFE] = 16'h0800;   // NOP

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    step(); step();
    check_all("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Free run
    step(); check_all("run0", 16'h0002, 16'h2000, 16'h0002, 1'b1, 1'b0);
    step(); check_all("run1", 16'h0004, 16'h2002, 16'h0004, 1'b1, 1'b0);

    // Stall three cycles at PC=0004
    stall = 1'b1;
    step(); check_all("stall1", 16'h0004, 16'h2002, 16'h0004, 1'b1, 1'b0);
    step(); check_all("stall2", 16'h0004, 16'h2002, 16'h0004, 1'b1, 1'b0);
    step(); check_all("stall3", 16'h0004, 16'h2002, 16'h0004, 1'b1, 1'b0);
    stall = 1'b0;
    step(); check_all("unstall", 16'h0006, 16'h2004, 16'h0006, 1'b1, 1'b0);

    // Redirect wins over stall (imem_data at 0006 is a HALT and must be dropped too)
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    step(); check_all("redir_bub", 16'h0100, 16'h0800, 16'h0000, 1'b0, 1'b0);
    stall = 1'b0; redirect = 1'b0;
    step(); check_all("redir_tgt", 16'h0102, 16'h2100, 16'h0102, 1'b1, 1'b0);

    // HALT at 0006
    redirect = 1'b1; redirect_pc = 16'h0004;
    step(); check_all("to4", 16'h0004, 16'h0800, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); check_all("pre_halt", 16'h0006, 16'h2004, 16'h0006, 1'b1, 1'b0);
    step(); check_all("halt", 16'h0006, 16'h0000, 16'h0008, 1'b1, 1'b1);
    step(); check_all("halt_bub1", 16'h0006, 16'h0800, 16'h0000, 1'b0, 1'b1);
    step(); check_all("halt_bub2", 16'h0006, 16'h0800, 16'h0000, 1'b0, 1'b1);
    redirect = 1'b1; redirect_pc = 16'h0010;
    step(); check_all("unhalt", 16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); check_all("resume", 16'h0012, 16'h2010, 16'h0012, 1'b1, 1'b0);

    // Redirect coinciding with a fetched HALT
    redirect = 1'b1; redirect_pc = 16'h0006;
    step(); check_all("at_halt", 16'h0006, 16'h0800, 16'h0000, 1'b0, 1'b0);
    redirect_pc = 16'h0020;
    step(); check_all("redir_vs_halt", 16'h0020, 16'h0800, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); check_all("after_vs_halt", 16'h0022, 16'h2020, 16'h0022, 1'b1, 1'b0);

    // PC wrap
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step(); check_all("wrap_bub", 16'hFFFE, 16'h0800, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); check_all("wrap_nop", 16'h0000, 16'h0800, 16'h0000, 1'b1, 1'b0);
    step(); check_all("wrap_next", 16'h0002, 16'h2000, 16'h0002, 1'b1, 1'b0);

    // Reset mid-stream overrides redirect
    rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0300;
    step(); check_all("rst_redir", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0; redirect = 1'b0;
    step(); check_all("post_rst", 16'h0002, 16'h2000, 16'h0002, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
